// File: rtl/mem_pp_writer.sv
// mem_pp_writer
//   Upstream feeder for the PP vector memory. Scalar elements arrive on a
//   valid/ready stream. no_of_units of them are packed into one memory word,
//   and each packed word is written with a one-cycle write_enable strobe.
//   After total_elements elements have been written, finish pulses for one
//   cycle.
//
//   Handshake: an element transfers on a rising clk edge where
//   in_valid & in_ready. in_ready is high only in COLLECT. in_valid may drop
//   at any time. The producer must hold in_data stable while in_valid is
//   high and no transfer has occurred.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               begins a run; ignored unless IDLE
//   in_data/in_valid    scalar element stream (sink side)
//   in_ready            element accepted when in_valid & in_ready
//   write_enable        one-cycle memory write strobe per packed word
//   input_write_address word address of the current write
//   input_data          packed word, lane 0 in the least significant bits
//   busy                run in progress
//   finish              one-cycle pulse, the cycle after the final write
//
// Every output is a flop that loads from the next-state value. Each output
// therefore tracks the state register exactly, with no combinational path
// from input to output. state_q is the FSM state for checkers to probe.
module mem_pp_writer #(
   parameter int                       element_width  = 64,
   parameter int                       no_of_units    = 8,
   parameter int                       address_width  = 20,
   parameter logic [address_width-1:0] base_address   = '0,
   parameter int                       total_elements = 72
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic [element_width-1:0]              in_data,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic                                  write_enable,
   output logic [address_width-1:0]              input_write_address,
   output logic [no_of_units*element_width-1:0]  input_data,
   output logic                                  busy,
   output logic                                  finish
);

   localparam int WORD_W = no_of_units * element_width;
   localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;
   localparam int CNT_W  = $clog2(total_elements + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   state_e                     state_q, state_d;
   logic [LANE_W-1:0]          lane_q, lane_d;
   logic [CNT_W-1:0]           elem_q, elem_d;
   logic [WORD_W-1:0]          stage_q, stage_d;
   logic [WORD_W-1:0]          data_q, data_d;
   logic [address_width-1:0]   addr_q, addr_d;
   logic                       ready_q, we_q, busy_q, finish_q;

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      elem_d  = elem_q;
      stage_d = stage_q;
      data_d  = data_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_COLLECT;
               lane_d  = '0;
               elem_d  = '0;
               stage_d = '0;
            end
         end
         S_COLLECT: begin
            if (in_valid) begin
               stage_d[lane_q*element_width +: element_width] = in_data;
               elem_d = elem_q + CNT_W'(1);
               // Close the word on a full lane set or on the run's last
               // element. The output word includes the element just
               // accepted. The staging word then starts empty, so the
               // unused upper lanes of a partial last word are written as 0.
               if (lane_q == LANE_W'(no_of_units - 1) ||
                   elem_q == CNT_W'(total_elements - 1)) begin
                  state_d = S_WRITE;
                  data_d  = stage_d;
                  stage_d = '0;
                  lane_d  = '0;
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
            end
         end
         S_WRITE: begin
            // Wraps modulo 2^address_width by natural truncation.
            addr_d  = addr_q + address_width'(1);
            state_d = (elem_q == CNT_W'(total_elements)) ? S_DONE : S_COLLECT;
         end
         S_DONE: begin
            addr_d  = base_address;
            elem_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lane_q   <= '0;
         elem_q   <= '0;
         stage_q  <= '0;
         data_q   <= '0;
         addr_q   <= base_address;
         ready_q  <= 1'b0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         elem_q   <= elem_d;
         stage_q  <= stage_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
         ready_q  <= (state_d == S_COLLECT);
         we_q     <= (state_d == S_WRITE);
         busy_q   <= (state_d != S_IDLE);
         finish_q <= (state_d == S_DONE);
      end
   end

   assign in_ready            = ready_q;
   assign write_enable        = we_q;
   assign input_write_address = addr_q;
   assign input_data          = data_q;
   assign busy                = busy_q;
   assign finish              = finish_q;

endmodule
